// File: rtl/monitor_alarme_usina_pkg.sv
// Shared types and constants for the plant alarm blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   estado_canal_e     per-channel alarm state
//   clog2()            ceiling log2, usable in parameter expressions
//   default sample width and trip thresholds shared with other plant blocks
package pkg_usina;

  typedef enum logic [2:0] {
    NORMAL      = 3'd0,
    PENDENTE    = 3'd1,
    ATIVO       = 3'd2,
    RECONHECIDO = 3'd3,
    ATIVO_LIMPO = 3'd4
  } estado_canal_e;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int valor);
    int r;
    r = 0;
    while ((1 << r) < valor) r++;
    return r;
  endfunction

  localparam int         LARGURA_PADRAO     = 12;
  localparam int         HISTERESE_PADRAO   = 16;
  localparam logic [11:0] LIMIAR_TEMP_PADRAO = 12'd40;
  localparam logic [11:0] LIMIAR_PRES_PADRAO = 12'd7;
  localparam logic [11:0] LIMIAR_RAD_PADRAO  = 12'd1000;

endpackage

// File: rtl/monitor_alarme_usina_canal.sv
// One alarm channel: compare, hysteresis, persistence filter and latching state machine.
// Latency: trip pulse is combinational from the current sample; state is visible next cycle.
// Backpressure: none; every valid sample is consumed in the cycle it is presented.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   amostra_valida    sample qualifier; ack and inibir act regardless of it
//   amostra, limiar   sample and trip threshold
//   ack               operator acknowledge pulse
//   inibir            maintenance inhibit, forces NORMAL
//   estado            current state
//   disparo           this cycle's edge moves NORMAL/PENDENTE -> ATIVO
//   alarme            latched (ATIVO, RECONHECIDO, ATIVO_LIMPO)
//   sirene            unacknowledged (ATIVO, ATIVO_LIMPO)
module canal_alarme
  import pkg_usina::*;
#(
  parameter int   LARGURA   = 12,
  parameter int   PERSIST   = 4,
  parameter int   HISTERESE = 16,
  parameter logic MODO_GT   = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               amostra_valida,
  input  logic [LARGURA-1:0] amostra,
  input  logic [LARGURA-1:0] limiar,
  input  logic               ack,
  input  logic               inibir,
  output estado_canal_e      estado,
  output logic               disparo,
  output logic               alarme,
  output logic               sirene
);

  localparam int CW  = (clog2(PERSIST + 1) < 1) ? 1 : clog2(PERSIST + 1);
  localparam int LW1 = LARGURA + 1;
  localparam logic [CW-1:0]  PERSIST_C = CW'(PERSIST);
  localparam logic [LW1-1:0] HIST_C    = LW1'(HISTERESE);

  estado_canal_e estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [LW1-1:0] soma_hist;
  logic          acima;
  logic          limpo;

  assign acima = MODO_GT ? (amostra > limiar) : (amostra >= limiar);

  // One extra bit so amostra + HISTERESE cannot wrap; a threshold at or
  // below the margin therefore never reports clear.
  assign soma_hist = {1'b0, amostra} + HIST_C;
  assign limpo     = soma_hist < {1'b0, limiar};

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    disparo  = 1'b0;
    if (inibir) begin
      estado_d = NORMAL;
      cnt_d    = '0;
    end else begin
      unique case (estado_q)
        NORMAL: begin
          if (amostra_valida && acima) begin
            if (PERSIST <= 1) begin
              estado_d = ATIVO;
              disparo  = 1'b1;
              cnt_d    = '0;
            end else begin
              estado_d = PENDENTE;
              cnt_d    = CW'(1);
            end
          end
        end
        PENDENTE: begin
          // Invalid cycles hold the count; only a valid non-over sample restarts it.
          if (amostra_valida) begin
            if (acima) begin
              if (cnt_inc >= PERSIST_C) begin
                estado_d = ATIVO;
                disparo  = 1'b1;
                cnt_d    = '0;
              end else begin
                cnt_d = cnt_inc;
              end
            end else begin
              estado_d = NORMAL;
              cnt_d    = '0;
            end
          end
        end
        ATIVO: begin
          if (ack && amostra_valida && limpo) estado_d = NORMAL;
          else if (ack)                       estado_d = RECONHECIDO;
          else if (amostra_valida && limpo)   estado_d = ATIVO_LIMPO;
        end
        RECONHECIDO: begin
          if (amostra_valida && limpo) estado_d = NORMAL;
        end
        ATIVO_LIMPO: begin
          // Returning over the limit re-arms the siren but is not a new trip.
          if (ack)                          estado_d = NORMAL;
          else if (amostra_valida && acima) estado_d = ATIVO;
        end
        default: begin
          estado_d = NORMAL;
          cnt_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q <= NORMAL;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
    end
  end

  assign estado = estado_q;
  assign alarme = (estado_q == ATIVO) || (estado_q == RECONHECIDO) || (estado_q == ATIVO_LIMPO);
  assign sirene = (estado_q == ATIVO) || (estado_q == ATIVO_LIMPO);

endmodule

// File: rtl/monitor_alarme_usina.sv
// N-channel control-room alarm monitor with first-out capture, trip counter and siren.
// Latency: a trip appears on all outputs the cycle after the qualifying valid sample.
// Backpressure: none; samples are accepted every cycle amostra_valida is high.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   amostra_valida      samples valid this cycle
//   amostras, limiares  packed samples/thresholds, channel i at [i*LARGURA +: LARGURA]
//   ack                 operator acknowledge pulse, all channels
//   inibir              per-channel maintenance inhibit
//   alarme_canal        per-channel latched alarm
//   alarmeSonoroSC      siren, any channel unacknowledged
//   primeiro_canal      lowest index of the first trip since the last ack
//   primeiro_valido     primeiro_canal holds a captured value
//   contagem_disparos   saturating count of trips since reset
module monitor_alarme_usina
  import pkg_usina::*;
#(
  parameter int                  N_CANAIS     = 3,
  parameter int                  LARGURA      = 12,
  parameter int                  PERSIST      = 4,
  parameter int                  HISTERESE    = 16,
  parameter logic [N_CANAIS-1:0] MODO_GT      = N_CANAIS'(3'b001),
  parameter int                  LARGURA_CONT = 8,
  localparam int                 LARGURA_IDX  = (clog2(N_CANAIS) < 1) ? 1 : clog2(N_CANAIS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           amostra_valida,
  input  logic [N_CANAIS*LARGURA-1:0]    amostras,
  input  logic [N_CANAIS*LARGURA-1:0]    limiares,
  input  logic                           ack,
  input  logic [N_CANAIS-1:0]            inibir,
  output logic [N_CANAIS-1:0]            alarme_canal,
  output logic                           alarmeSonoroSC,
  output logic [LARGURA_IDX-1:0]         primeiro_canal,
  output logic                           primeiro_valido,
  output logic [LARGURA_CONT-1:0]        contagem_disparos
);

  // Sum width covers the counter plus up to 16 simultaneous trips.
  localparam int LS = LARGURA_CONT + 6;
  localparam logic [LS-1:0] CONT_MAX = {{6{1'b0}}, {LARGURA_CONT{1'b1}}};

  logic [N_CANAIS-1:0] disparo;
  logic [N_CANAIS-1:0] sirene;

  logic [LARGURA_IDX-1:0]  primeiro_canal_q, primeiro_canal_d;
  logic                    primeiro_valido_q, primeiro_valido_d;
  logic [LARGURA_CONT-1:0] contagem_q, contagem_d;

  logic [LARGURA_IDX-1:0] idx_disparo;
  logic [LS-1:0]          n_disparos;
  logic [LS-1:0]          soma_cont;

  for (genvar g = 0; g < N_CANAIS; g++) begin : g_canal
    estado_canal_e estado_g;

    canal_alarme #(
      .LARGURA   (LARGURA),
      .PERSIST   (PERSIST),
      .HISTERESE (HISTERESE),
      .MODO_GT   (MODO_GT[g])
    ) u_canal (
      .clk            (clk),
      .rst_n          (rst_n),
      .amostra_valida (amostra_valida),
      .amostra        (amostras[g*LARGURA +: LARGURA]),
      .limiar         (limiares[g*LARGURA +: LARGURA]),
      .ack            (ack),
      .inibir         (inibir[g]),
      .estado         (estado_g),
      .disparo        (disparo[g]),
      .alarme         (alarme_canal[g]),
      .sirene         (sirene[g])
    );
  end

  always_comb begin
    idx_disparo = '0;
    n_disparos  = '0;
    // Descending scan so the lowest tripping index wins.
    for (int i = N_CANAIS - 1; i >= 0; i--) begin
      if (disparo[i]) idx_disparo = LARGURA_IDX'(i);
    end
    for (int i = 0; i < N_CANAIS; i++) begin
      n_disparos = n_disparos + LS'(disparo[i]);
    end

    primeiro_canal_d  = primeiro_canal_q;
    primeiro_valido_d = primeiro_valido_q;
    // A trip in the ack cycle replaces the capture being cleared.
    if ((|disparo) && (!primeiro_valido_q || ack)) begin
      primeiro_canal_d  = idx_disparo;
      primeiro_valido_d = 1'b1;
    end else if (ack) begin
      primeiro_valido_d = 1'b0;
    end

    soma_cont  = LS'(contagem_q) + n_disparos;
    contagem_d = (soma_cont > CONT_MAX) ? {LARGURA_CONT{1'b1}} : LARGURA_CONT'(soma_cont);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      primeiro_canal_q  <= '0;
      primeiro_valido_q <= 1'b0;
      contagem_q        <= '0;
    end else begin
      primeiro_canal_q  <= primeiro_canal_d;
      primeiro_valido_q <= primeiro_valido_d;
      contagem_q        <= contagem_d;
    end
  end

  assign alarmeSonoroSC    = |sirene;
  assign primeiro_canal    = primeiro_canal_q;
  assign primeiro_valido   = primeiro_valido_q;
  assign contagem_disparos = contagem_q;

endmodule

// File: tb/tb_monitor_alarme_usina.sv
// Scoreboard bench for monitor_alarme_usina at default parameters.
// Driver issues one sample set per cycle and queues the reference model's expected outputs;
// a monitor on the falling edge pops and compares them.
module tb_monitor_alarme_usina;

  localparam int N    = 3;
  localparam int L    = 12;
  localparam int PERS = 4;
  localparam int HIST = 16;

  typedef struct {
    logic [2:0] alarme;
    logic       sirene;
    logic       fv;
    logic [1:0] fc;
    logic [7:0] cont;
  } esperado_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          amostra_valida;
  logic [N*L-1:0] amostras;
  logic [N*L-1:0] limiares;
  logic          ack;
  logic [N-1:0]  inibir;
  logic [N-1:0]  alarme_canal;
  logic          alarmeSonoroSC;
  logic [1:0]    primeiro_canal;
  logic          primeiro_valido;
  logic [7:0]    contagem_disparos;

  monitor_alarme_usina dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .amostra_valida    (amostra_valida),
    .amostras          (amostras),
    .limiares          (limiares),
    .ack               (ack),
    .inibir            (inibir),
    .alarme_canal      (alarme_canal),
    .alarmeSonoroSC    (alarmeSonoroSC),
    .primeiro_canal    (primeiro_canal),
    .primeiro_valido   (primeiro_valido),
    .contagem_disparos (contagem_disparos)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  esperado_t sb[$];

  // Reference model: a channel is "latched" once it has seen PERS consecutive
  // valid over-limit samples; flags record acknowledgement and having cleared.
  int LIM[3]    = '{40, 7, 1000};
  bit GT[3]     = '{1'b1, 1'b0, 1'b0};
  int run[3];
  bit lat[3];
  bit ackd[3];
  bit limpou[3];
  bit m_fv;
  int m_fc;
  int m_cont;

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_chk++;
    if (atual !== esperado) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, atual, esperado, $time);
    end
  endtask

  task automatic modelo_reset();
    for (int c = 0; c < 3; c++) begin
      run[c] = 0; lat[c] = 0; ackd[c] = 0; limpou[c] = 0;
    end
    m_fv = 0; m_fc = 0; m_cont = 0;
  endtask

  // Drive one cycle, advance the model, queue the expected post-edge outputs.
  task automatic ciclo(input bit v, input int s0, input int s1, input int s2,
                       input bit a, input bit [2:0] inb, input bit rst_ativo = 1'b0);
    int s[3];
    bit acima, limpo;
    bit [2:0] trip;
    esperado_t e;
    int menor;
    s[0] = s0; s[1] = s1; s[2] = s2;
    rst_n          = ~rst_ativo;
    amostra_valida = v;
    amostras       = {L'(s2), L'(s1), L'(s0)};
    ack            = a;
    inibir         = inb;
    trip           = '0;
    if (rst_ativo) begin
      modelo_reset();
    end else begin
      for (int c = 0; c < 3; c++) begin
        acima = GT[c] ? (s[c] > LIM[c]) : (s[c] >= LIM[c]);
        limpo = (s[c] + HIST) < LIM[c];
        if (inb[c]) begin
          lat[c] = 0; run[c] = 0;
        end else if (!lat[c]) begin
          if (v) begin
            run[c] = acima ? run[c] + 1 : 0;
            if (run[c] >= PERS) begin
              trip[c] = 1; lat[c] = 1; ackd[c] = 0; limpou[c] = 0; run[c] = 0;
            end
          end
        end else if (ackd[c]) begin
          if (v && limpo) lat[c] = 0;
        end else if (limpou[c]) begin
          if (a) lat[c] = 0;
          else if (v && acima) limpou[c] = 0;
        end else begin
          if (a) begin
            if (v && limpo) lat[c] = 0;
            else ackd[c] = 1;
          end else if (v && limpo) begin
            limpou[c] = 1;
          end
        end
      end
      menor = -1;
      for (int c = 2; c >= 0; c--) if (trip[c]) menor = c;
      if (menor >= 0 && (!m_fv || a)) begin
        m_fv = 1; m_fc = menor;
      end else if (a) begin
        m_fv = 0;
      end
      m_cont = m_cont + int'(trip[0]) + int'(trip[1]) + int'(trip[2]);
      if (m_cont > 255) m_cont = 255;
    end
    e.alarme = {lat[2], lat[1], lat[0]};
    e.sirene = (lat[0] && !ackd[0]) || (lat[1] && !ackd[1]) || (lat[2] && !ackd[2]);
    e.fv     = m_fv;
    e.fc     = 2'(m_fc);
    e.cont   = 8'(m_cont);
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  task automatic limpar();
    ciclo(0, 0, 0, 0, 1'b1, 3'b111);
  endtask

  // Monitor
  initial begin
    esperado_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("alarme_canal", 32'(alarme_canal), 32'(e.alarme));
        chk("alarmeSonoroSC", 32'(alarmeSonoroSC), 32'(e.sirene));
        chk("primeiro_valido", 32'(primeiro_valido), 32'(e.fv));
        if (e.fv) chk("primeiro_canal", 32'(primeiro_canal), 32'(e.fc));
        chk("contagem_disparos", 32'(contagem_disparos), 32'(e.cont));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    limiares = {12'd1000, 12'd7, 12'd40};
    rst_n = 1'b0; amostra_valida = 1'b0; amostras = '0; ack = 1'b0; inibir = '0;

    // Reset held with all channels over the limit.
    repeat (3) ciclo(1, 100, 100, 2000, 1'b0, 3'b000, 1'b1);
    // Release: trips only on the 4th valid sample.
    repeat (5) ciclo(1, 100, 100, 2000, 1'b0, 3'b000);
    limpar();

    // Persistence on ch0 (strict >), with invalid gaps holding the count.
    ciclo(1, 41, 0, 0, 0, 0);
    ciclo(0, 41, 0, 0, 0, 0);
    ciclo(1, 41, 0, 0, 0, 0);
    ciclo(1, 41, 0, 0, 0, 0);
    ciclo(1, 41, 0, 0, 0, 0);
    ciclo(1, 41, 0, 0, 0, 0);
    limpar();
    repeat (6) ciclo(1, 40, 0, 0, 0, 0);
    repeat (3) ciclo(1, 41, 0, 0, 0, 0);
    ciclo(1, 39, 0, 0, 0, 0);
    repeat (3) ciclo(1, 41, 0, 0, 0, 0);
    ciclo(1, 41, 0, 0, 0, 0);
    limpar();

    // Hysteresis and acknowledge on ch2.
    repeat (4) ciclo(1, 0, 0, 1000, 0, 0);
    ciclo(0, 0, 0, 1000, 1, 0);
    ciclo(1, 0, 0, 990, 0, 0);
    ciclo(1, 0, 0, 984, 0, 0);
    ciclo(1, 0, 0, 983, 0, 0);
    ciclo(1, 0, 0, 983, 0, 0);
    limpar();

    // Clear-before-ack: ch1 (threshold inside the margin) and ch0.
    repeat (4) ciclo(1, 0, 7, 0, 0, 0);
    repeat (2) ciclo(1, 0, 0, 0, 0, 0);
    ciclo(0, 0, 0, 0, 1, 0);
    limpar();
    repeat (4) ciclo(1, 41, 0, 0, 0, 0);
    ciclo(1, 20, 0, 0, 0, 0);
    ciclo(1, 20, 0, 0, 0, 0);
    ciclo(1, 30, 0, 0, 0, 0);
    ciclo(1, 20, 0, 0, 0, 0);
    ciclo(0, 20, 0, 0, 1, 0);
    limpar();

    // Simultaneous trip on ch1/ch2, then ch0 trips in an ack cycle.
    repeat (4) ciclo(1, 0, 50, 1500, 0, 0);
    repeat (3) ciclo(1, 45, 50, 1500, 0, 0);
    ciclo(1, 45, 50, 1500, 1, 0);
    ciclo(1, 45, 50, 1500, 0, 0);
    limpar();

    // Inhibit on ch0, then release.
    repeat (6) ciclo(1, 200, 0, 0, 0, 3'b001);
    repeat (4) ciclo(1, 200, 0, 0, 0, 3'b000);
    limpar();

    // Randomized traffic around the thresholds.
    for (int k = 0; k < 1500; k++) begin
      ciclo(($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 70)),
            int'($urandom_range(0, 30)),
            int'($urandom_range(960, 1030)),
            ($urandom_range(0, 7) == 0),
            {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)});
    end

    // Counter saturation: three trips per round, inhibit pulse to re-arm.
    for (int k = 0; k < 90; k++) begin
      repeat (4) ciclo(1, 100, 100, 2000, 0, 0);
      ciclo(0, 0, 0, 0, 0, 3'b111);
    end
    repeat (2) ciclo(1, 0, 0, 0, 0, 0);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
